// File: rtl/serial_slave_port.sv
// serial_slave_port: bit-serial bus slave with local register file; define SLAVE_SPLIT_EN to add split on reads
module serial_slave_port #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 8,
    parameter int SPLIT_CYCLES = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic mode,
    input  logic wr_bus,
    input  logic master_valid,
    input  logic master_ready,
    output logic rd_bus,
    output logic slave_ready,
    output logic slave_valid,
    output logic split
);
    localparam int CW = $clog2((ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH) + 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        WRITE,
`ifdef SLAVE_SPLIT_EN
        SPLIT,
`endif
        READ,
        RDATA
    } state_t;

`ifdef SLAVE_SPLIT_EN
    localparam state_t RD_ENTRY = SPLIT;
    localparam int SW = $clog2(SPLIT_CYCLES + 1);
    logic [SW-1:0] scnt;
`else
    localparam state_t RD_ENTRY = READ;
`endif

    if (ADDR_WIDTH < 2 || DATA_WIDTH < 2 || SPLIT_CYCLES < 1) begin : g_bad_params
        $error("serial_slave_port: ADDR_WIDTH/DATA_WIDTH must be >= 2 and SPLIT_CYCLES >= 1");
    end

    state_t                state, next;
    logic [CW-1:0]         count;
    logic                  mode_q;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic                  acc, beat;

    assign slave_ready = state inside {IDLE, ADDR, WDATA};
    assign slave_valid = state == RDATA;
    assign rd_bus      = slave_valid & shreg[DATA_WIDTH-1];
    assign acc         = master_valid & slave_ready;
    assign beat        = slave_valid & master_ready;
`ifdef SLAVE_SPLIT_EN
    assign split       = state == SPLIT;
`else
    assign split       = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= next;
    end

    // Next-state decode; each serial phase ends on its last accepted bit or beat
    always_comb begin
        next = state;
        case (state)
            IDLE:    if (acc) next = ADDR;
            ADDR:    if (acc && count == CW'(ADDR_WIDTH - 1)) next = mode_q ? WDATA : RD_ENTRY;
            WDATA:   if (acc && count == CW'(DATA_WIDTH - 1)) next = WRITE;
            WRITE:   next = IDLE;
`ifdef SLAVE_SPLIT_EN
            SPLIT:   if (scnt == SW'(SPLIT_CYCLES - 1)) next = READ;
`endif
            READ:    next = RDATA;
            RDATA:   if (beat && count == CW'(DATA_WIDTH - 1)) next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Shift registers and counters; count restarts whenever a serial phase completes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count  <= '0;
            mode_q <= 1'b0;
            addr   <= '0;
            shreg  <= '0;
`ifdef SLAVE_SPLIT_EN
            scnt   <= '0;
`endif
        end else begin
            if (acc && state == IDLE) mode_q <= mode;
            if (acc && state != WDATA) addr <= {addr[ADDR_WIDTH-2:0], wr_bus};
            if (acc && state == WDATA) shreg <= {shreg[DATA_WIDTH-2:0], wr_bus};
            else if (state == READ)    shreg <= mem[addr];
            else if (beat)             shreg <= shreg << 1;
            count <= (next != state && state != IDLE) ? '0 : (acc || beat) ? count + 1'b1 : count;
`ifdef SLAVE_SPLIT_EN
            scnt  <= (state == SPLIT && next == SPLIT) ? scnt + 1'b1 : '0;
`endif
        end
    end

    // Register file write; only a fully received write reaches WRITE
    always_ff @(posedge clk) begin
        if (state == WRITE) mem[addr] <= shreg;
    end
endmodule

// File: tb/tb_serial_slave_port.sv
// tb_serial_slave_port: directed bench for serial_slave_port (split checks follow SLAVE_SPLIT_EN)
module tb_serial_slave_port;
    logic clk = 0, rstn = 0, mode = 0, wr_bus = 0, master_valid = 0, master_ready = 0;
    logic rd_bus, slave_ready, slave_valid, split;
    int vectors = 0, miscompares = 0;
    logic split_seen = 0;
    logic [7:0] d;
    int v, s;

`ifdef SLAVE_SPLIT_EN
    localparam int EXP_SPLIT = 16;
`else
    localparam int EXP_SPLIT = 0;
`endif

    serial_slave_port dut (
        .clk(clk), .rstn(rstn), .mode(mode), .wr_bus(wr_bus),
        .master_valid(master_valid), .master_ready(master_ready),
        .rd_bus(rd_bus), .slave_ready(slave_ready), .slave_valid(slave_valid), .split(split)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (split) split_seen <= 1'b1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic b);
        wr_bus = b;
        master_valid = 1;
        @(negedge clk);
    endtask

    task automatic send_addr(input logic [11:0] a, input int stall_at);
        for (int i = 11; i >= 0; i--) begin
            if (11 - i == stall_at) begin
                for (int k = 0; k < 5; k++) begin
                    master_valid = 0;
                    wr_bus = ~wr_bus;
                    @(negedge clk);
                end
            end
            put(a[i]);
            mode = 0;
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [7:0] dat, input int stall_at, input string tag);
        mode = 1;
        send_addr(a, stall_at);
        for (int i = 7; i >= 0; i--) put(dat[i]);
        master_valid = 0;
        check({tag, "_ready_in_write"}, slave_ready, 0);
        @(negedge clk);
        check({tag, "_ready_idle"}, slave_ready, 1);
    endtask

    task automatic rd(input logic [11:0] a, input logic toggle, input logic junk, input string tag,
                      output logic [7:0] dat, output int vcyc, output int scyc);
        int beats = 0;
        logic hold_bit = 0, have_hold = 0, ph = 0;
        mode = 0;
        send_addr(a, -1);
        master_valid = junk;
        wr_bus = 1;
        dat = 0; vcyc = 0; scyc = 0;
        for (int c = 0; c < 300 && beats < 8; c++) begin
            if (split) scyc++;
            if (slave_valid) begin
                vcyc++;
                master_ready = toggle ? ph : 1'b1;
                ph = ~ph;
                if (have_hold) check({tag, "_hold"}, rd_bus, hold_bit);
                if (master_ready) begin
                    dat = {dat[6:0], rd_bus};
                    beats++;
                    have_hold = 0;
                end else begin
                    hold_bit = rd_bus;
                    have_hold = 1;
                end
            end else master_ready = 0;
            @(negedge clk);
        end
        master_valid = 0;
        master_ready = 0;
        check({tag, "_beats"}, beats, 8);
        check({tag, "_valid_drop"}, slave_valid, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rstn = 1;
        check("rst_rd_bus", rd_bus, 0);
        check("rst_slave_valid", slave_valid, 0);
        check("rst_split", split, 0);
        check("rst_slave_ready", slave_ready, 1);
        @(negedge clk);

        wr(12'h0A5, 8'h3C, -1, "w_0a5");
        rd(12'h0A5, 0, 0, "r_0a5", d, v, s);
        check("r_0a5_data", d, 8'h3C);
        check("r_0a5_valid_cycles", v, 8);

        wr(12'hFFF, 8'h81, -1, "w_fff");
        rd(12'hFFF, 1, 0, "r_fff_tog", d, v, s);
        check("r_fff_data", d, 8'h81);
        check("r_fff_valid_cycles", v, 16);

        wr(12'h000, 8'hA7, -1, "w_000");
        rd(12'h000, 0, 1, "r_000_junk", d, v, s);
        check("r_000_data", d, 8'hA7);

        wr(12'h123, 8'h5A, 6, "w_stall");
        rd(12'h123, 0, 0, "r_stall", d, v, s);
        check("r_stall_data", d, 8'h5A);
        rd(12'h0A5, 0, 0, "r_0a5_again", d, v, s);
        check("r_0a5_again_data", d, 8'h3C);

        wr(12'h200, 8'h11, -1, "w_200");
        mode = 1;
        send_addr(12'h200, -1);
        for (int i = 0; i < 3; i++) put(1'b1);
        master_valid = 0;
        rstn = 0;
        @(negedge clk);
        rstn = 1;
        @(negedge clk);
        rd(12'h200, 0, 0, "r_abort", d, v, s);
        check("r_abort_data", d, 8'h11);

        mode = 0;
        send_addr(12'h0A5, -1);
        master_valid = 0;
        master_ready = 1;
        for (int c = 0; c < 40 && !slave_valid; c++) @(negedge clk);
        check("rd_reset_started", slave_valid, 1);
        @(negedge clk);
        rstn = 0;
        #1;
        check("rd_reset_valid", slave_valid, 0);
        check("rd_reset_rd_bus", rd_bus, 0);
        check("rd_reset_ready", slave_ready, 1);
        @(negedge clk);
        rstn = 1;
        master_ready = 0;
        @(negedge clk);

        wr(12'h001, 8'h6B, -1, "w_001");
        rd(12'h001, 0, 0, "r_001", d, v, s);
        check("r_001_data", d, 8'h6B);
        check("r_001_split_cycles", s, EXP_SPLIT);
`ifndef SLAVE_SPLIT_EN
        check("split_never_seen", split_seen, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/serial_slave_port.md
Name: serial_slave_port

Overview:
- Bit-serial slave endpoint for the system bus: the responder side of the master/arbiter serial handshake.
- The arbiter forwards a slave's `_mode`, `_wr_bus`, `_master_valid` and `_master_ready` signals only to the selected slave. This block receives the serial address and write data, and accesses a local register-file memory.
- On reads it returns data serially over `rd_bus`.
- Instantiated once per slave (S1/S2/S3). Its ports connect directly to the arbiter's `sN_*` signals and to `slave_split`.

Parameters:
- ADDR_WIDTH, 12, local address bits received serially, MSB first; memory depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, data word bits, serial MSB first in both directions.
- SPLIT_CYCLES, 16, read-access latency during which the slave holds split (used only with SLAVE_SPLIT_EN).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- mode  input  1  transaction type; 1 = write, 0 = read; sampled with the first address bit.
- wr_bus  input  1  serial master-to-slave bit (address, then write data).
- master_valid  input  1  wr_bus bit valid this cycle.
- master_ready  input  1  master accepts the current rd_bus bit.
- rd_bus  output  1  serial slave-to-master read data bit.
- slave_ready  output  1  slave accepts a wr_bus bit this cycle.
- slave_valid  output  1  rd_bus bit valid this cycle.
- split  output  1  slave requests bus release during a long read.

Behaviour:
- Clock/reset: one clock, clk. Reset rstn is asynchronous, active-low.
- Reset values:
  - state = IDLE; bit counter = 0; address and data shift registers = 0.
  - rd_bus = 0, slave_valid = 0, split = 0, slave_ready = 1 (slave_ready is decoded from state).
  - Memory contents are not reset.
- Accepted bit: a cycle with master_valid && slave_ready. Read beat: a cycle with slave_valid && master_ready.
- master_valid low stalls the current phase indefinitely; there is no timeout.
- slave_ready = 1 in IDLE, ADDR and WDATA; 0 in all other states.
- slave_valid = 1 only in RDATA.
- FSM states: IDLE, ADDR, WDATA, WRITE, SPLIT, READ, RDATA.
- IDLE:
  - On an accepted bit: latch mode, shift wr_bus into addr[ADDR_WIDTH-1], set count = 1, go to ADDR.
- ADDR:
  - Each accepted bit shifts into the next lower address bit and increments count.
  - When the ADDR_WIDTH-th bit is accepted, count is cleared and the next state depends on the latched mode:
    - mode = 1: go to WDATA.
    - mode = 0: go to SPLIT if enabled, else READ.
- WDATA:
  - Shift DATA_WIDTH accepted bits MSB first.
  - The cycle after the last bit is accepted: go to WRITE.
- WRITE (1 cycle):
  - Write mem[addr] = data, then go to IDLE.
  - Write latency is 1 cycle after the last data bit.
- READ (1 cycle):
  - Load the shift register with mem[addr]; rd_bus presents its MSB from the next cycle.
  - Go to RDATA.
- RDATA:
  - rd_bus = shreg MSB.
  - On each read beat: shift left and increment count.
  - After the DATA_WIDTH-th beat: slave_valid drops the next cycle and the FSM returns to IDLE.
  - master_ready low holds the current bit stable.
- Minimum transaction length:
  - Write: ADDR_WIDTH + DATA_WIDTH + 1 cycles.
  - Read: ADDR_WIDTH + 1 + DATA_WIDTH cycles, plus split time when enabled.
- Boundaries:
  - Address 0 and address 2**ADDR_WIDTH-1 are both valid; there is no out-of-range case.
  - A back-to-back transaction may start in the cycle after returning to IDLE.
  - master_valid high during WRITE, READ or RDATA is ignored (slave_ready = 0 there).
  - rstn low mid-transaction aborts immediately to the reset values. A partially received write never reaches memory.

Optional Feature:
- Macro: SLAVE_SPLIT_EN.
- Defined:
  - Read address completion enters SPLIT.
  - split = 1 and slave_ready = 0 for exactly SPLIT_CYCLES cycles, counted by a dedicated counter.
  - split then drops to 0 and the FSM goes to READ, then RDATA. This emulates a slow device so the arbiter can release and later reconnect the bus.
  - Writes never split.
- Not defined:
  - The SPLIT state and its counter are not built; split is tied to 0.
  - ADDR goes directly to READ.

Test Plan:
- Reset release: rstn low then high -> rd_bus = 0, slave_valid = 0, split = 0, slave_ready = 1.
- Write addr 0x0A5, data 0x3C, master_valid continuous -> mem[0x0A5] = 0x3C; slave_ready low for exactly 1 cycle after bit 20, then high in IDLE.
- Read back addr 0x0A5, master_ready held high -> rd_bus emits 0,0,1,1,1,1,0,0 on 8 consecutive slave_valid cycles; slave_valid drops after the 8th.
- Read addr 0xFFF (pre-written 0x81) with master_ready toggling 1,0 -> each bit is held while master_ready = 0; 0x81 is received intact over 16 cycles.
- Write with master_valid deasserted 5 cycles mid-address -> stall, no shift; completed write lands at the correct address. Separately, rstn pulsed after 3 data bits -> the target word is unchanged.
- With SLAVE_SPLIT_EN, SPLIT_CYCLES = 16, read addr 0x001 -> split high for exactly 16 cycles after the 12th address bit, then the data is returned. Without the macro, split stays 0 throughout.
